// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command host.
// Holds frame opcodes, command type and FSM state encodings, and the per-command byte count.
package uart_cmd_pkg;

  localparam logic [7:0] OPC_WR      = 8'hAA;
  localparam logic [7:0] OPC_RD      = 8'hBB;
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CmdRegWr  = 2'd0,
    CmdRegRd  = 2'd1,
    CmdAluOp  = 2'd2,
    CmdAluNop = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4,
    StGap    = 3'd5
  } state_e;

  // Number of bytes on the wire for a command, opcode included.
  function automatic logic [2:0] cmd_bytes(cmd_type_e t);
    logic [2:0] n;
    unique case (t)
      CmdRegWr:  n = 3'd3;
      CmdRegRd:  n = 3'd2;
      CmdAluOp:  n = 3'd4;
      CmdAluNop: n = 3'd2;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_cmd_host_if.sv
// Command handshake bundle between a command source and uart_cmd_host.
//   master: drives cmd_valid and the command fields, observes cmd_ready.
//   slave : observes cmd_valid and the command fields, drives cmd_ready.
interface uart_cmd_host_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_fun;

  modport master (
    output cmd_valid, cmd_type, cmd_addr, cmd_a, cmd_b, cmd_fun,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_addr, cmd_a, cmd_b, cmd_fun,
    output cmd_ready
  );
endinterface

// File: rtl/uart_cmd_bit_timer.sv
// Loadable bit-period down-counter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : start a new period of period_i cycles (period_i must be non-zero)
//   period_i     : bit period in clock cycles
//   en_i         : count enable; the counter auto-reloads at each period end while enabled
//   tick_o       : high on the last cycle of every period
module uart_cmd_bit_timer #(
  parameter int unsigned CPB_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CPB_W-1:0] period_i,
  input  logic             en_i,
  output logic             tick_o
);

  logic [CPB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = period_i - CPB_W'(1);
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? period_i - CPB_W'(1) : cnt_q - CPB_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_host.sv
// Host-side command serializer driving a UART RX pin.
// Accepts one command per handshake and sends opcode + operand bytes as async frames:
// start, 8 data bits LSB first, optional parity, stop; GAP_BITS idle periods between bytes.
//   CLK, RST     : clock, synchronous active-high reset
//   cmd          : command handshake (slave side), see uart_cmd_host_if
//   par_en       : parity enable; par_typ 0=even, 1=odd
//   clks_per_bit : bit period in CLK cycles, 0 treated as 1
//   err_inject   : only with UART_CMD_HOST_ERR_INJ_EN; inverts parity bits and
//                  drives the final stop bit low
//   tx_line      : serial output, idle high
//   busy         : high from accept until the end of the final stop bit
//   cmd_done     : pulse on the last cycle of the final stop bit
module uart_cmd_host
  import uart_cmd_pkg::*;
#(
  parameter int unsigned GAP_BITS = 1,
  parameter int unsigned CPB_W    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  uart_cmd_host_if.slave   cmd,
  input  logic             par_en,
  input  logic             par_typ,
  input  logic [CPB_W-1:0] clks_per_bit,
`ifdef UART_CMD_HOST_ERR_INJ_EN
  input  logic             err_inject,
`endif
  output logic             tx_line,
  output logic             busy,
  output logic             cmd_done
);

  localparam int unsigned GapW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

  state_e           state_q, state_d;
  cmd_type_e        type_q;
  logic [3:0]       addr_q, fun_q;
  logic [7:0]       a_q, b_q;
  logic             par_en_q, par_typ_q, err_q;
  logic [CPB_W-1:0] cpb_q;
  logic [2:0]       bit_idx_q;
  logic [1:0]       byte_idx_q;
  logic [GapW-1:0]  gap_cnt_q;

  logic             accept, bit_tick, last_byte, last_gap, err_in;
  logic [CPB_W-1:0] cpb_in, period;
  logic [7:0]       cur_byte;

`ifdef UART_CMD_HOST_ERR_INJ_EN
  assign err_in = err_inject;
`else
  assign err_in = 1'b0;
`endif

  assign accept    = cmd.cmd_valid && cmd.cmd_ready;
  assign cpb_in    = (clks_per_bit == '0) ? CPB_W'(1) : clks_per_bit;
  // The live input only matters on the accept edge; afterwards the latched copy is used.
  assign period    = accept ? cpb_in : cpb_q;
  assign last_byte = ({1'b0, byte_idx_q} == (cmd_bytes(type_q) - 3'd1));
  assign last_gap  = (gap_cnt_q == GapLast);

  uart_cmd_bit_timer #(
    .CPB_W (CPB_W)
  ) u_bit_timer (
    .clk_i    (CLK),
    .rst_i    (RST),
    .load_i   (accept),
    .period_i (period),
    .en_i     (state_q != StIdle),
    .tick_o   (bit_tick)
  );

  // Byte currently on the wire.
  always_comb begin
    cur_byte = 8'h00;
    unique case (type_q)
      CmdRegWr: begin
        case (byte_idx_q)
          2'd0:    cur_byte = OPC_WR;
          2'd1:    cur_byte = {4'h0, addr_q};
          default: cur_byte = a_q;
        endcase
      end
      CmdRegRd: begin
        cur_byte = (byte_idx_q == 2'd0) ? OPC_RD : {4'h0, addr_q};
      end
      CmdAluOp: begin
        case (byte_idx_q)
          2'd0:    cur_byte = OPC_ALU_OP;
          2'd1:    cur_byte = a_q;
          2'd2:    cur_byte = b_q;
          default: cur_byte = {4'h0, fun_q};
        endcase
      end
      CmdAluNop: begin
        cur_byte = (byte_idx_q == 2'd0) ? OPC_ALU_NOP : {4'h0, fun_q};
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StStart;
      StStart:  if (bit_tick) state_d = StData;
      StData:   if (bit_tick && (bit_idx_q == 3'd7)) state_d = par_en_q ? StParity : StStop;
      StParity: if (bit_tick) state_d = StStop;
      StStop: begin
        if (bit_tick) begin
          if (last_byte)         state_d = StIdle;
          else if (GAP_BITS > 0) state_d = StGap;
          else                   state_d = StStart;
        end
      end
      StGap:    if (bit_tick && last_gap) state_d = StStart;
      default:  state_d = StIdle;
    endcase
  end

  // Command latch and bit/byte/gap indices.
  always_ff @(posedge CLK) begin
    if (RST) begin
      type_q     <= CmdRegWr;
      addr_q     <= '0;
      fun_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      err_q      <= 1'b0;
      cpb_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      gap_cnt_q  <= '0;
    end else if (accept) begin
      type_q     <= cmd_type_e'(cmd.cmd_type);
      addr_q     <= cmd.cmd_addr;
      fun_q      <= cmd.cmd_fun;
      a_q        <= cmd.cmd_a;
      b_q        <= cmd.cmd_b;
      par_en_q   <= par_en;
      par_typ_q  <= par_typ;
      err_q      <= err_in;
      cpb_q      <= cpb_in;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      gap_cnt_q  <= '0;
    end else if (bit_tick) begin
      case (state_q)
        // 3-bit index wraps back to 0 after bit 7, ready for the next byte.
        StData: bit_idx_q <= bit_idx_q + 3'd1;
        StStop: if (!last_byte) byte_idx_q <= byte_idx_q + 2'd1;
        StGap:  gap_cnt_q <= last_gap ? '0 : gap_cnt_q + GapW'(1);
        default: ;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    tx_line       = 1'b1;
    busy          = (state_q != StIdle);
    cmd.cmd_ready = (state_q == StIdle);
    cmd_done      = 1'b0;
    unique case (state_q)
      StStart:  tx_line = 1'b0;
      StData:   tx_line = cur_byte[bit_idx_q];
      StParity: tx_line = (^cur_byte) ^ par_typ_q ^ err_q;
      StStop: begin
        tx_line  = ~(err_q & last_byte);
        // Suppressed under reset so an abandoned command never reports completion.
        cmd_done = bit_tick && last_byte && !RST;
      end
      default:  tx_line = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed bench for uart_cmd_host: captures tx_line per cycle after each accept and
// compares it with an independently built frame waveform and hand-computed bytes.
module tb_uart_cmd_host;

  localparam int unsigned GapBits = 1;
  localparam int unsigned CpbW    = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            par_en, par_typ;
  logic [CpbW-1:0] clks_per_bit;
  logic            tx_line, busy, cmd_done;
`ifdef UART_CMD_HOST_ERR_INJ_EN
  logic            err_inject;
`endif

  always #5 clk = ~clk;

  uart_cmd_host_if cmd_if ();

  uart_cmd_host #(
    .GAP_BITS (GapBits),
    .CPB_W    (CpbW)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .cmd          (cmd_if),
    .par_en       (par_en),
    .par_typ      (par_typ),
    .clks_per_bit (clks_per_bit),
`ifdef UART_CMD_HOST_ERR_INJ_EN
    .err_inject   (err_inject),
`endif
    .tx_line      (tx_line),
    .busy         (busy),
    .cmd_done     (cmd_done)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic       wave [1:4096];
  logic       exp_w [$];
  logic [7:0] exp_bytes [4];
  logic       exp_par [4];
  int         exp_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected tx_line per cycle after the accept edge, from the frame format.
  task automatic build_exp(input logic pen, input logic ptyp, input int cpb, input logic err);
    logic last;
    exp_w.delete();
    for (int i = 0; i < exp_n; i++) begin
      last = (i == exp_n - 1);
      repeat (cpb) exp_w.push_back(1'b0);
      for (int j = 0; j < 8; j++) repeat (cpb) exp_w.push_back(exp_bytes[i][j]);
      if (pen) repeat (cpb) exp_w.push_back((^exp_bytes[i]) ^ ptyp ^ err);
      repeat (cpb) exp_w.push_back(!(err && last));
      if (!last) repeat (GapBits * cpb) exp_w.push_back(1'b1);
    end
  endtask

  task automatic issue(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] fun, input logic pen,
                       input logic ptyp, input logic [7:0] cpb);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    cmd_if.cmd_type  = t;
    cmd_if.cmd_addr  = addr;
    cmd_if.cmd_a     = a;
    cmd_if.cmd_b     = b;
    cmd_if.cmd_fun   = fun;
    par_en           = pen;
    par_typ          = ptyp;
    clks_per_bit     = cpb;
    cmd_if.cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_if.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept_ready", ok, 1);
    @(posedge clk);
  endtask

  // Call right after the accept edge; poke_at > 0 fires a cmd_valid pulse with junk fields.
  task automatic capture(input int poke_at, output int done_at);
    done_at = -1;
    for (int k = 1; k < 4000; k++) begin
      @(negedge clk);
      wave[k] = tx_line;
      if (poke_at > 0 && k == poke_at) begin
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_type  = 2'd2;
        cmd_if.cmd_a     = 8'hFF;
        cmd_if.cmd_b     = 8'hFF;
        par_en           = ~par_en;
        clks_per_bit     = 8'd9;
      end
      if (poke_at > 0 && k == poke_at + 1) cmd_if.cmd_valid = 1'b0;
      if (cmd_done) begin
        done_at = k;
        break;
      end
    end
  endtask

  task automatic compare(input string tag, input int done_at, input int exp_done,
                         input logic pen, input int cpb);
    int         mism;
    int         stride;
    logic [7:0] got;
    mism = 0;
    check({tag, "_done_cycle"}, done_at, exp_done);
    for (int k = 1; k <= exp_w.size(); k++) if (wave[k] !== exp_w[k-1]) mism++;
    check({tag, "_wave_mismatches"}, mism, 0);
    stride = (pen ? 11 : 10) * cpb + GapBits * cpb;
    for (int i = 0; i < exp_n; i++) begin
      for (int j = 0; j < 8; j++) got[j] = wave[i * stride + cpb * (1 + j) + 1];
      check({tag, "_byte"}, got, exp_bytes[i]);
      if (pen) check({tag, "_parity"}, wave[i * stride + 9 * cpb + 1], exp_par[i]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d;
    int done_cnt;
    int low_cnt;

    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_type = 2'd0;
    cmd_if.cmd_addr = 4'h0;
    cmd_if.cmd_a = 8'h00;
    cmd_if.cmd_b = 8'h00;
    cmd_if.cmd_fun = 4'h0;
    par_en = 1'b0;
    par_typ = 1'b0;
    clks_per_bit = 8'd4;
`ifdef UART_CMD_HOST_ERR_INJ_EN
    err_inject = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_tx_line", tx_line, 1);
    check("reset_busy", busy, 0);
    check("reset_cmd_done", cmd_done, 0);
    check("reset_cmd_ready", cmd_if.cmd_ready, 1);

    // REG_WR addr=5 a=0x3C, no parity, cpb=4; a busy-time valid pulse must be ignored.
    exp_bytes[0] = 8'hAA; exp_bytes[1] = 8'h05; exp_bytes[2] = 8'h3C; exp_n = 3;
    issue(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0, 8'd4);
    #1 cmd_if.cmd_valid = 1'b0;
    check("wr_busy_after_accept", busy, 1);
    capture(10, d);
    build_exp(1'b0, 1'b0, 4, 1'b0);
    compare("reg_wr", d, 128, 1'b0, 4);
    @(negedge clk);
    check("wr_ready_after_done", cmd_if.cmd_ready, 1);
    check("wr_busy_after_done", busy, 0);

    // ALU_OP a=0x12 b=0x34 fun=1, even parity, cpb=2.
    exp_bytes[0] = 8'hCC; exp_bytes[1] = 8'h12; exp_bytes[2] = 8'h34; exp_bytes[3] = 8'h01;
    exp_par[0] = 1'b0; exp_par[1] = 1'b0; exp_par[2] = 1'b1; exp_par[3] = 1'b1; exp_n = 4;
    issue(2'd2, 4'h0, 8'h12, 8'h34, 4'h1, 1'b1, 1'b0, 8'd2);
    #1 cmd_if.cmd_valid = 1'b0;
    capture(0, d);
    build_exp(1'b1, 1'b0, 2, 1'b0);
    compare("alu_op", d, 94, 1'b1, 2);

    // REG_RD addr=2, odd parity, cpb=0 behaves as 1.
    exp_bytes[0] = 8'hBB; exp_bytes[1] = 8'h02; exp_par[0] = 1'b1; exp_par[1] = 1'b0;
    exp_n = 2;
    issue(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 8'd0);
    #1 cmd_if.cmd_valid = 1'b0;
    capture(0, d);
    build_exp(1'b1, 1'b1, 1, 1'b0);
    compare("reg_rd_cpb0", d, 23, 1'b1, 1);

    // Back-to-back: ALU_NOP fun=3 with cmd_valid held, REG_RD addr=7 waiting behind it.
    exp_bytes[0] = 8'hDD; exp_bytes[1] = 8'h03; exp_n = 2;
    issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h3, 1'b0, 1'b0, 8'd2);
    #1;
    cmd_if.cmd_type = 2'd1;
    cmd_if.cmd_addr = 4'h7;
    capture(0, d);
    build_exp(1'b0, 1'b0, 2, 1'b0);
    compare("alu_nop", d, 42, 1'b0, 2);
    @(negedge clk);
    check("b2b_ready", cmd_if.cmd_ready, 1);
    check("b2b_busy_low", busy, 0);
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
    exp_bytes[0] = 8'hBB; exp_bytes[1] = 8'h07; exp_n = 2;
    capture(0, d);
    check("b2b_start_bit", wave[1], 0);
    build_exp(1'b0, 1'b0, 2, 1'b0);
    compare("b2b_reg_rd", d, 42, 1'b0, 2);

    // Reset in the middle of byte 2's data bits (bit 1 of 0x05 would be low next).
    issue(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0, 8'd4);
    #1 cmd_if.cmd_valid = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 54; k++) begin
      @(negedge clk);
      if (cmd_done) done_cnt++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tx_line_high", tx_line, 1);
    check("rst_busy_low", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_after", cmd_if.cmd_ready, 1);
    low_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_done) done_cnt++;
      if (!tx_line) low_cnt++;
    end
    check("rst_no_cmd_done", done_cnt, 0);
    check("rst_line_idle", low_cnt, 0);

`ifdef UART_CMD_HOST_ERR_INJ_EN
    // REG_WR addr=9 a=0x5A, even parity, injected errors: all parity bits flipped to 1.
    exp_bytes[0] = 8'hAA; exp_bytes[1] = 8'h09; exp_bytes[2] = 8'h5A;
    exp_par[0] = 1'b1; exp_par[1] = 1'b1; exp_par[2] = 1'b1; exp_n = 3;
    err_inject = 1'b1;
    issue(2'd0, 4'h9, 8'h5A, 8'h00, 4'h0, 1'b1, 1'b0, 8'd2);
    #1 cmd_if.cmd_valid = 1'b0;
    err_inject = 1'b0;
    capture(0, d);
    build_exp(1'b1, 1'b0, 2, 1'b1);
    compare("err_inj", d, 70, 1'b1, 2);
    check("err_inj_final_stop", wave[70], 0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
